// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Data-memory front end between the load/store units and the data cache.
//   Arbitrates NUM_LOAD_PORTS load channels and one buffered store channel
//   onto a single cache port. Stores are queued in a SB_DEPTH-entry FIFO.
//   Loads that hit a fully-written queued word are forwarded from the FIFO.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   load_req/address/id   per-port load request, address and tag (port i at slice i)
//   load_value/valid      per-port returned data and one-cycle completion pulse
//   load_id_out           tag of the load completing this cycle
//   stall_load            per-port: request not accepted this cycle
//   store_req/address/value/be, stall_store   store channel, stalled when buffer full
//   stall_in              downstream hold
//   dismiss_output        high while a store drain occupies the cache port
//   cache_*               single cache port (req/address/data/be/write, result/satisfied)
module mem_port_arbiter #(
    parameter int unsigned ADDRESS_SIZE   = 32,
    parameter int unsigned OPERAND_SIZE   = 32,
    parameter int unsigned NUM_LOAD_PORTS = 2,
    parameter int unsigned SB_DEPTH       = 4,
    parameter int unsigned ID_SIZE        = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_LOAD_PORTS-1:0]              load_req,
    input  logic [NUM_LOAD_PORTS*ADDRESS_SIZE-1:0] load_address,
    input  logic [NUM_LOAD_PORTS*ID_SIZE-1:0]      load_id,
    output logic [NUM_LOAD_PORTS*OPERAND_SIZE-1:0] load_value,
    output logic [NUM_LOAD_PORTS-1:0]              load_valid,
    output logic [ID_SIZE-1:0]                     load_id_out,
    output logic [NUM_LOAD_PORTS-1:0]              stall_load,
    input  logic                                   store_req,
    input  logic [ADDRESS_SIZE-1:0]                store_address,
    input  logic [OPERAND_SIZE-1:0]                store_value,
    input  logic [OPERAND_SIZE/8-1:0]              store_be,
    output logic                                   stall_store,
    input  logic                                   stall_in,
    output logic                                   dismiss_output,
    output logic                                   cache_req,
    output logic [ADDRESS_SIZE-1:0]                cache_address,
    output logic [OPERAND_SIZE-1:0]                cache_data,
    output logic [OPERAND_SIZE/8-1:0]              cache_be,
    output logic                                   cache_write,
    input  logic [OPERAND_SIZE-1:0]                cache_result,
    input  logic                                   cache_satisfied
);

    localparam int unsigned BE_W  = OPERAND_SIZE / 8;
    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LP_W  = (NUM_LOAD_PORTS > 1) ? $clog2(NUM_LOAD_PORTS) : 1;
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(BE_W - 1);
    localparam logic [CNT_W-1:0]        FULL       = CNT_W'(SB_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

    state_t state, state_n;

    logic [ADDRESS_SIZE-1:0] sb_addr [SB_DEPTH];
    logic [OPERAND_SIZE-1:0] sb_data [SB_DEPTH];
    logic [BE_W-1:0]         sb_be   [SB_DEPTH];
    logic [PTR_W-1:0]        head, tail;
    logic [CNT_W-1:0]        count;
    logic                    enq, deq;

    logic [ADDRESS_SIZE-1:0] st_al;
    logic [ADDRESS_SIZE-1:0] la       [NUM_LOAD_PORTS];
    logic [OPERAND_SIZE-1:0] fwd_data [NUM_LOAD_PORTS];
    logic [NUM_LOAD_PORTS-1:0] partial, fwd_hit, elig;

    logic [LP_W-1:0] rr_ptr, gnt, cand;
    logic            gnt_found, do_grant;

    logic [LP_W-1:0]         ld_port;
    logic [ID_SIZE-1:0]      ld_id;
    logic [ADDRESS_SIZE-1:0] ld_addr;
    logic                    pend;
    logic [OPERAND_SIZE-1:0] pend_data;

    assign st_al       = store_address & ALIGN_MASK;
    assign enq         = store_req && (count != FULL);
    assign deq         = (state == STORE_WAIT) && cache_satisfied;
    assign stall_store = store_req && (count == FULL);

    // Buffer lookup per port, oldest to youngest so the youngest match wins.
    always_comb begin
        for (int unsigned i = 0; i < NUM_LOAD_PORTS; i++) begin
            la[i]       = load_address[i*ADDRESS_SIZE +: ADDRESS_SIZE] & ALIGN_MASK;
            partial[i]  = 1'b0;
            fwd_hit[i]  = 1'b0;
            fwd_data[i] = '0;
            for (int unsigned k = 0; k < SB_DEPTH; k++) begin
                if ((CNT_W'(k) < count) && (sb_addr[head + PTR_W'(k)] == la[i])) begin
                    fwd_hit[i]  = &sb_be[head + PTR_W'(k)];
                    fwd_data[i] = sb_data[head + PTR_W'(k)];
                    partial[i]  = partial[i] | ~(&sb_be[head + PTR_W'(k)]);
                end
            end
            // A held completion result blocks new grants so only one pulse fires per cycle.
            elig[i] = load_req[i] && !stall_in && !pend && !partial[i] &&
                      !(store_req && (st_al == la[i]));
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        cand      = '0;
        for (int unsigned j = 0; j < NUM_LOAD_PORTS; j++) begin
            cand = LP_W'((32'(rr_ptr) + j) % NUM_LOAD_PORTS);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt       = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        do_grant = 1'b0;
        case (state)
            IDLE: begin
                if ((count == FULL) || (!gnt_found && (count != '0))) begin
                    state_n = STORE_WAIT;
                end else if (gnt_found) begin
                    do_grant = 1'b1;
                    if (!fwd_hit[gnt]) state_n = LOAD_WAIT;
                end
            end
            LOAD_WAIT:  if (cache_satisfied) state_n = IDLE;
            STORE_WAIT: if (cache_satisfied) state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LOAD_PORTS; i++) begin
            stall_load[i] = load_req[i] && !(do_grant && (gnt == LP_W'(i)));
        end
    end

    always_comb begin
        cache_req      = (state != IDLE);
        cache_write    = (state == STORE_WAIT);
        dismiss_output = (state == STORE_WAIT);
        cache_address  = '0;
        cache_data     = '0;
        cache_be       = '0;
        if (state == LOAD_WAIT) begin
            cache_address = ld_addr;
        end else if (state == STORE_WAIT) begin
            cache_address = sb_addr[head];
            cache_data    = sb_data[head];
            cache_be      = sb_be[head];
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr[tail] <= st_al;
            sb_data[tail] <= store_value;
            sb_be[tail]   <= store_be;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rr_ptr      <= '0;
            ld_port     <= '0;
            ld_id       <= '0;
            ld_addr     <= '0;
            pend        <= 1'b0;
            pend_data   <= '0;
            load_valid  <= '0;
            load_value  <= '0;
            load_id_out <= '0;
        end else begin
            state      <= state_n;
            load_valid <= '0;
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(deq);

            if (do_grant) begin
                rr_ptr  <= (gnt == LP_W'(NUM_LOAD_PORTS - 1)) ? '0 : gnt + LP_W'(1);
                ld_port <= gnt;
                ld_id   <= load_id[32'(gnt)*ID_SIZE +: ID_SIZE];
                ld_addr <= la[gnt];
                if (fwd_hit[gnt]) begin
                    load_valid[gnt]                               <= 1'b1;
                    load_value[32'(gnt)*OPERAND_SIZE +: OPERAND_SIZE] <= fwd_data[gnt];
                    load_id_out                                   <= load_id[32'(gnt)*ID_SIZE +: ID_SIZE];
                end
            end

            // Completion under stall_in is parked in pend_data and released once stall_in drops.
            if ((state == LOAD_WAIT) && cache_satisfied) begin
                if (stall_in) begin
                    pend      <= 1'b1;
                    pend_data <= cache_result;
                end else begin
                    load_valid[ld_port]                                   <= 1'b1;
                    load_value[32'(ld_port)*OPERAND_SIZE +: OPERAND_SIZE] <= cache_result;
                    load_id_out                                           <= ld_id;
                end
            end
            if (pend && !stall_in) begin
                pend                                                  <= 1'b0;
                load_valid[ld_port]                                   <= 1'b1;
                load_value[32'(ld_port)*OPERAND_SIZE +: OPERAND_SIZE] <= pend_data;
                load_id_out                                           <= ld_id;
            end
        end
    end

endmodule
